ef_uart_tx_arbiter: RTL and testbench

Round-robin packet arbiter that shares one EF_UART transmitter among several byte-stream requesters. It sits between up to N client streams (valid/ready/last) and the UART core's TX FIFO write port. It locks the winning requester for a whole packet and enforces a programmable inter-packet gap. A starvation timeout releases a requester that stalls mid-packet.

---
 rtl/ef_uart_tx_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_ef_uart_tx_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ef_uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// ef_uart_tx_arbiter
//
// Round-robin packet arbiter that shares one EF_UART TX FIFO write port among
// N_REQ byte-stream requesters. A requester is granted in IDLE, keeps the lock
// for a whole packet (up to and including its req_last byte), and is followed
// by GAP_CYCLES idle clocks. An owner that leaves its valid low for TIMEOUT
// consecutive clocks is forcibly released and timeout_err pulses once.
//
// Handshake: a byte moves from the owner to the FIFO in any BUSY cycle where
// req_valid[grant_id]=1 and tx_fifo_full=0. In that cycle tx_wr=1 and
// req_ready[grant_id]=1. req_ready depends only on state, grant and
// tx_fifo_full, never on req_valid. Non-owners always see req_ready=0.
//
// Ports:
//   clk           clock, rising edge
//   rst_n         asynchronous active-low reset
//   req_valid     per-requester byte valid            [N_REQ]
//   req_data      per-requester byte, i at [8i+7:8i]  [8*N_REQ]
//   req_last      per-requester end-of-packet marker  [N_REQ]
//   req_ready     per-requester accept                [N_REQ]
//   tx_fifo_full  UART TX FIFO full
//   tx_wr         FIFO write strobe
//   tx_wdata      FIFO write data (0 whenever tx_wr=0)
//   busy          a requester holds the lock (state BUSY)
//   grant_id      current / last owner index
//   timeout_err   one-cycle pulse on forced release
//   dbg_state     FSM state (0 IDLE, 1 BUSY, 2 GAP)
//   dbg_rr_ptr    round-robin scan start index
// ----------------------------------------------------------------------------
module ef_uart_tx_arbiter #(
   parameter int N_REQ      = 4,
   parameter int GAP_CYCLES = 2,
   parameter int TIMEOUT    = 1024,
   localparam int GW        = $clog2(N_REQ)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N_REQ-1:0]     req_valid,
   input  logic [8*N_REQ-1:0]   req_data,
   input  logic [N_REQ-1:0]     req_last,
   output logic [N_REQ-1:0]     req_ready,
   input  logic                 tx_fifo_full,
   output logic                 tx_wr,
   output logic [7:0]           tx_wdata,
   output logic                 busy,
   output logic [GW-1:0]        grant_id,
   output logic                 timeout_err,
   output logic [1:0]           dbg_state,
   output logic [GW-1:0]        dbg_rr_ptr
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   // Stall counter only ever needs to hold TIMEOUT-1; keep at least one bit
   // so a disabled timeout still elaborates.
   localparam int SW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam int CW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   localparam logic [SW-1:0] STALL_LAST = SW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [CW-1:0] GAP_LOAD   = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   // Where a finished or abandoned packet goes next.
   localparam state_t END_ST = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;

   state_t         state_q, state_d;
   logic [GW-1:0]  rr_ptr_q, rr_ptr_d;
   logic [GW-1:0]  grant_id_q, grant_id_d;
   logic [SW-1:0]  stall_q, stall_d;
   logic [CW-1:0]  gap_q, gap_d;
   logic           timeout_err_q, timeout_err_d;

   logic           owner_valid;
   logic           owner_last;
   logic [7:0]     owner_data;
   logic           in_busy;
   logic           hs;
   logic [GW-1:0]  next_ptr;
   logic           any_valid;
   logic           found;
   int             pick_idx;
   logic [GW-1:0]  pick;

   // -------------------------------------------------------------------------
   // Owner view and datapath
   // -------------------------------------------------------------------------
   always_comb begin
      owner_valid = req_valid[grant_id_q];
      owner_last  = req_last[grant_id_q];
      owner_data  = req_data[8*grant_id_q +: 8];
      in_busy     = (state_q == ST_BUSY);
      hs          = in_busy & owner_valid & ~tx_fifo_full;

      next_ptr = (grant_id_q == GW'(N_REQ - 1)) ? '0 : grant_id_q + GW'(1);

      req_ready = '0;
      if (in_busy) begin
         req_ready[grant_id_q] = ~tx_fifo_full;
      end
      tx_wr    = hs;
      tx_wdata = hs ? owner_data : 8'h00;
   end

   // -------------------------------------------------------------------------
   // Round-robin pick: first valid requester at or above rr_ptr, with wrap.
   // -------------------------------------------------------------------------
   always_comb begin
      any_valid = |req_valid;
      found     = 1'b0;
      pick_idx  = 0;
      pick      = rr_ptr_q;
      for (int k = 0; k < N_REQ; k++) begin
         pick_idx = (int'(rr_ptr_q) + k) % N_REQ;
         if (!found && req_valid[pick_idx]) begin
            found = 1'b1;
            pick  = GW'(pick_idx);
         end
      end
   end

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d       = state_q;
      rr_ptr_d      = rr_ptr_q;
      grant_id_d    = grant_id_q;
      stall_d       = stall_q;
      gap_d         = gap_q;
      timeout_err_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (any_valid) begin
               grant_id_d = pick;
               stall_d    = '0;
               state_d    = ST_BUSY;
            end
         end

         ST_BUSY: begin
            if (hs) begin
               stall_d = '0;
               if (owner_last) begin
                  rr_ptr_d = next_ptr;
                  gap_d    = GAP_LOAD;
                  state_d  = END_ST;
               end
            end else if (!owner_valid) begin
               // Owner idle: a stall. Backpressure (valid & full) holds the
               // counter instead, so a slow UART never triggers a release.
               if ((TIMEOUT > 0) && (stall_q == STALL_LAST)) begin
                  timeout_err_d = 1'b1;
                  stall_d       = '0;
                  rr_ptr_d      = next_ptr;
                  gap_d         = GAP_LOAD;
                  state_d       = END_ST;
               end else if (TIMEOUT > 0) begin
                  stall_d = stall_q + SW'(1);
               end
            end
         end

         ST_GAP: begin
            if (gap_q == '0) begin
               state_d = ST_IDLE;
            end else begin
               gap_d = gap_q - CW'(1);
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         rr_ptr_q      <= '0;
         grant_id_q    <= '0;
         stall_q       <= '0;
         gap_q         <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         rr_ptr_q      <= rr_ptr_d;
         grant_id_q    <= grant_id_d;
         stall_q       <= stall_d;
         gap_q         <= gap_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign busy        = in_busy;
   assign grant_id    = grant_id_q;
   assign timeout_err = timeout_err_q;
   assign dbg_state   = state_q;
   assign dbg_rr_ptr  = rr_ptr_q;

endmodule

// File: tb/tb_ef_uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ef_uart_tx_arbiter
//
// Directed bench for ef_uart_tx_arbiter (N_REQ=4, GAP_CYCLES=2, TIMEOUT=16).
// Each cycle starts 1 time unit after the rising edge: inputs are applied,
// then outputs are checked 1 unit later, well before the next edge.
// ----------------------------------------------------------------------------
module tb_ef_uart_tx_arbiter;

   localparam int N   = 4;
   localparam int GAP = 2;
   localparam int TO  = 16;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_GAP  = 2'd2;

   // clock / reset
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [N-1:0]   vld;
   logic [N-1:0]   lst;
   logic [7:0]     dat [N];
   logic [8*N-1:0] req_data;
   logic           full;

   logic [N-1:0]   req_ready;
   logic           tx_wr;
   logic [7:0]     tx_wdata;
   logic           busy;
   logic [1:0]     grant_id;
   logic           timeout_err;
   logic [1:0]     dbg_state;
   logic [1:0]     dbg_rr_ptr;

   assign req_data = {dat[3], dat[2], dat[1], dat[0]};

   ef_uart_tx_arbiter #(
      .N_REQ      (N),
      .GAP_CYCLES (GAP),
      .TIMEOUT    (TO)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (vld),
      .req_data     (req_data),
      .req_last     (lst),
      .req_ready    (req_ready),
      .tx_fifo_full (full),
      .tx_wr        (tx_wr),
      .tx_wdata     (tx_wdata),
      .busy         (busy),
      .grant_id     (grant_id),
      .timeout_err  (timeout_err),
      .dbg_state    (dbg_state),
      .dbg_rr_ptr   (dbg_rr_ptr)
   );

   int total = 0;
   int bad   = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      vld  = '0;
      lst  = '0;
      full = 1'b0;
      for (int i = 0; i < N; i++) dat[i] = 8'h00;
      rst_n = 1'b0;

      // ---------------- reset values ----------------
      tick();
      tick();
      #1;
      chk("rst_busy",    busy,        0);
      chk("rst_wr",      tx_wr,       0);
      chk("rst_wdata",   tx_wdata,    0);
      chk("rst_ready",   req_ready,   0);
      chk("rst_grant",   grant_id,    0);
      chk("rst_to",      timeout_err, 0);
      chk("rst_state",   dbg_state,   S_IDLE);
      chk("rst_rr",      dbg_rr_ptr,  0);
      rst_n = 1'b1;
      tick();

      // ---------------- round robin: 1-byte packets from all ----------------
      vld = 4'hF;
      lst = 4'hF;
      for (int i = 0; i < N; i++) dat[i] = 8'h10 + 8'(i);
      #1;
      chk("rr_idle_wr",    tx_wr, 0);
      chk("rr_idle_ready", req_ready, 0);
      for (int k = 0; k < 5; k++) begin
         tick(); #1;
         chk("rr_grant", grant_id, k % 4);
         chk("rr_data",  tx_wdata, 8'h10 + k % 4);
         chk("rr_wr",    tx_wr,    1);
         chk("rr_busy",  busy,     1);
         if (k < 4) begin
            tick(); #1;
            chk("rr_gap_wr",   tx_wr,     0);
            chk("rr_gap_busy", busy,      0);
            chk("rr_gap_ready", req_ready, 0);
            tick();
            tick();
         end
      end
      tick();
      vld = '0;
      #1;
      chk("rr_ptr_after", dbg_rr_ptr, 1);
      chk("rr_end_state", dbg_state,  S_GAP);
      tick();
      tick();  // IDLE, rr_ptr = 1

      // ---------------- packet lock: req1 4 bytes, req0 waiting ----------------
      vld    = 4'b0011;
      lst    = 4'b0001;
      dat[0] = 8'h33;
      dat[1] = 8'hA0;
      #1;
      chk("lock_idle_state", dbg_state, S_IDLE);
      for (int j = 0; j < 4; j++) begin
         tick();
         dat[1] = 8'hA0 + 8'(j);
         lst[1] = (j == 3);
         #1;
         chk("lock_grant", grant_id,  1);
         chk("lock_wr",    tx_wr,     1);
         chk("lock_data",  tx_wdata,  8'hA0 + j);
         chk("lock_ready", req_ready, 4'b0010);
      end
      tick(); #1;
      chk("lock_gap_busy",  busy,      0);
      chk("lock_gap_ready", req_ready, 0);
      chk("lock_gap_wdata", tx_wdata,  0);
      tick();
      tick();
      tick(); #1;
      chk("lock_next_grant", grant_id,  0);
      chk("lock_next_data",  tx_wdata,  8'h33);
      chk("lock_next_ready", req_ready, 4'b0001);
      tick();
      vld = '0;
      lst = '0;
      tick();
      tick();  // IDLE, rr_ptr = 1

      // ---------------- backpressure: 2000 full cycles mid-packet ----------------
      vld    = 4'b0010;
      dat[1] = 8'hB0;
      tick(); #1;
      chk("bp_first_wr",   tx_wr,    1);
      chk("bp_first_data", tx_wdata, 8'hB0);
      tick();
      dat[1] = 8'hB1;
      full   = 1'b1;
      #1;
      chk("bp_ready", req_ready, 0);
      chk("bp_busy",  busy,      1);
      for (int c = 0; c < 2000; c++) begin
         chk("bp_wr", tx_wr,       0);
         chk("bp_to", timeout_err, 0);
         tick(); #1;
      end
      full = 1'b0;
      #1;
      chk("bp_resume_wr",    tx_wr,     1);
      chk("bp_resume_data",  tx_wdata,  8'hB1);
      chk("bp_resume_ready", req_ready, 4'b0010);
      tick();
      dat[1] = 8'hB2;
      lst[1] = 1'b1;
      #1;
      chk("bp_last_wr",   tx_wr,    1);
      chk("bp_last_data", tx_wdata, 8'hB2);
      tick();
      vld = '0;
      lst = '0;
      #1;
      chk("bp_end_state", dbg_state,   S_GAP);
      chk("bp_end_to",    timeout_err, 0);
      chk("bp_end_rr",    dbg_rr_ptr,  2);
      tick();
      tick();  // IDLE, rr_ptr = 2

      // ---------------- timeout: req2 sends one byte then stalls ----------------
      vld    = 4'b1101;
      lst    = 4'b1001;
      dat[0] = 8'hE0;
      dat[2] = 8'hC0;
      dat[3] = 8'hD0;
      tick(); #1;  // handshake cycle h
      chk("to_grant", grant_id, 2);
      chk("to_wr",    tx_wr,    1);
      chk("to_data",  tx_wdata, 8'hC0);
      tick();
      vld = 4'b1001;
      #1;           // h+1
      for (int c = 0; c < TO; c++) begin
         chk("to_wait_busy",  busy,        1);
         chk("to_wait_to",    timeout_err, 0);
         chk("to_wait_ready", req_ready,   4'b0100);
         chk("to_wait_wr",    tx_wr,       0);
         tick(); #1;
      end
      // h+17
      chk("to_pulse",       timeout_err, 1);
      chk("to_pulse_busy",  busy,        0);
      chk("to_pulse_state", dbg_state,   S_GAP);
      chk("to_rr",          dbg_rr_ptr,  3);
      tick(); #1;
      chk("to_pulse_end",   timeout_err, 0);
      tick();
      tick(); #1;
      chk("to_next_grant", grant_id, 3);
      chk("to_next_data",  tx_wdata, 8'hD0);
      tick();
      vld    = 4'b0011;
      dat[1] = 8'hF0;
      lst    = 4'b0001;
      tick();
      tick();
      tick(); #1;
      chk("to_wrap_grant", grant_id, 0);
      chk("to_wrap_data",  tx_wdata, 8'hE0);
      tick();
      vld = 4'b0010;
      tick();
      tick();
      tick(); #1;
      chk("rs_pre_grant", grant_id, 1);
      chk("rs_pre_data",  tx_wdata, 8'hF0);

      // ---------------- asynchronous reset mid-packet ----------------
      tick();
      dat[1] = 8'hF1;
      #1;
      chk("rs_mid_wr",   tx_wr,    1);
      chk("rs_mid_data", tx_wdata, 8'hF1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("rs_busy",  busy,       0);
      chk("rs_wr",    tx_wr,      0);
      chk("rs_ready", req_ready,  0);
      chk("rs_wdata", tx_wdata,   0);
      chk("rs_grant", grant_id,   0);
      chk("rs_rr",    dbg_rr_ptr, 0);
      tick();
      tick();
      rst_n  = 1'b1;
      vld    = 4'b1010;
      lst    = 4'b1010;
      dat[1] = 8'hF0;
      dat[3] = 8'hD1;
      #1;
      chk("rs_rel_state", dbg_state, S_IDLE);
      chk("rs_rel_wr",    tx_wr,     0);
      tick(); #1;
      chk("rs_scan_grant", grant_id, 1);
      chk("rs_scan_data",  tx_wdata, 8'hF0);
      chk("rs_scan_wr",    tx_wr,    1);
      vld = '0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
